// File: rtl/fb_scroll_ctrl.sv
// rtl/fb_scroll_ctrl.sv - waterfall frame buffer sequencer: clear, video reads, scroll-line copy
// Define FB_CLEAR_EN to zero the whole frame buffer after reset before video starts.
module fb_scroll_ctrl #(
  parameter int H_VISIBLE  = 320,
  parameter int V_VISIBLE  = 240,
  parameter int LIMIT_BINS = 320,
  parameter int SCROLL_DIV = 4,
  parameter int FB_ADDR_W  = 17,
  parameter int BIN_ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            x,
  input  logic [7:0]            y,
  input  logic                  lower_blank,
  output logic [BIN_ADDR_W-1:0] bin_addr,
  output logic                  bin_rd_en,
  input  logic [7:0]            bin_data,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [7:0]            fb_wdata,
  output logic                  fb_we,
  output logic [7:0]            y_offset,
  output logic                  ready
);

  typedef enum logic [1:0] {CLEAR, VIDEO, WRITE, WAIT} state_t;

  localparam int FC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [FB_ADDR_W-1:0]  H_MUL    = FB_ADDR_W'(H_VISIBLE);
  localparam logic [FB_ADDR_W-1:0]  FB_LAST  = FB_ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [BIN_ADDR_W-1:0] BIN_LAST = BIN_ADDR_W'(LIMIT_BINS - 1);
  localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(SCROLL_DIV - 1);
  localparam logic [8:0]            V_VIS9   = 9'(V_VISIBLE);
  localparam logic [7:0]            Y_LAST   = 8'(V_VISIBLE - 1);

`ifdef FB_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = VIDEO;
`endif

  // Row stride multiply unrolls into one shifted add per set bit of H_VISIBLE.
  function automatic logic [FB_ADDR_W-1:0] mul_h(input logic [7:0] r);
    logic [FB_ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FB_ADDR_W; i++) begin
      if (H_MUL[i]) acc = acc + (FB_ADDR_W'(r) << i);
    end
    return acc;
  endfunction

  state_t                  state_q, state_d;
  logic [FB_ADDR_W-1:0]    fb_addr_q, fb_addr_d;
  logic                    fb_we_q, fb_we_d;
  logic                    wr_phase_q, wr_phase_d;
  logic [BIN_ADDR_W-1:0]   bin_addr_q, bin_addr_d;
  logic                    bin_rd_en_q, bin_rd_en_d;
  logic                    last_q, last_d;
  logic [7:0]              y_offset_q, y_offset_d;
  logic                    ready_q, ready_d;
  logic [FC_W-1:0]         frame_q, frame_d;

  logic [8:0]              row_sum;
  logic [7:0]              row;
  logic [FB_ADDR_W-1:0]    row_base;

  always_comb begin
    row_sum  = {1'b0, y} + {1'b0, y_offset_q};
    row      = (row_sum >= V_VIS9) ? 8'(row_sum - V_VIS9) : row_sum[7:0];
    row_base = mul_h(y_offset_q);

    state_d     = state_q;
    fb_addr_d   = fb_addr_q;
    fb_we_d     = fb_we_q;
    wr_phase_d  = wr_phase_q;
    bin_addr_d  = bin_addr_q;
    bin_rd_en_d = bin_rd_en_q;
    last_d      = last_q;
    y_offset_d  = y_offset_q;
    ready_d     = ready_q;
    frame_d     = frame_q;

    case (state_q)
      CLEAR: begin
        if (!fb_we_q) begin
          fb_we_d   = 1'b1;
          fb_addr_d = '0;
        end else if (fb_addr_q == FB_LAST) begin
          fb_we_d = 1'b0;
          ready_d = 1'b1;
          state_d = VIDEO;
        end else begin
          fb_addr_d = fb_addr_q + FB_ADDR_W'(1);
        end
      end
      VIDEO: begin
        fb_we_d = 1'b0;
        if (lower_blank) begin
          if (frame_q == FC_LAST) begin
            frame_d     = '0;
            state_d     = WRITE;
            bin_addr_d  = '0;
            bin_rd_en_d = 1'b1;
            last_d      = 1'b0;
          end else begin
            frame_d = frame_q + FC_W'(1);
            state_d = WAIT;
          end
        end else begin
          fb_addr_d = FB_ADDR_W'(x) + mul_h(row);
        end
      end
      WRITE: begin
        // Each write targets the bin addressed one cycle earlier; bin_data arrives in step.
        if (last_q) begin
          fb_we_d     = 1'b0;
          wr_phase_d  = 1'b0;
          bin_rd_en_d = 1'b0;
          bin_addr_d  = '0;
          last_d      = 1'b0;
          y_offset_d  = (y_offset_q == Y_LAST) ? 8'd0 : y_offset_q + 8'd1;
          state_d     = WAIT;
        end else begin
          fb_we_d    = 1'b1;
          wr_phase_d = 1'b1;
          fb_addr_d  = row_base + FB_ADDR_W'(bin_addr_q);
          if (bin_addr_q == BIN_LAST) last_d = 1'b1;
          else bin_addr_d = bin_addr_q + BIN_ADDR_W'(1);
        end
      end
      WAIT: begin
        if (!lower_blank) state_d = VIDEO;
      end
      default: state_d = RESET_STATE;
    endcase

`ifndef FB_CLEAR_EN
    ready_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      fb_addr_q   <= '0;
      fb_we_q     <= 1'b0;
      wr_phase_q  <= 1'b0;
      bin_addr_q  <= '0;
      bin_rd_en_q <= 1'b0;
      last_q      <= 1'b0;
      y_offset_q  <= 8'd0;
      ready_q     <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      fb_addr_q   <= fb_addr_d;
      fb_we_q     <= fb_we_d;
      wr_phase_q  <= wr_phase_d;
      bin_addr_q  <= bin_addr_d;
      bin_rd_en_q <= bin_rd_en_d;
      last_q      <= last_d;
      y_offset_q  <= y_offset_d;
      ready_q     <= ready_d;
      frame_q     <= frame_d;
    end
  end

  assign bin_addr  = bin_addr_q;
  assign bin_rd_en = bin_rd_en_q;
  assign fb_addr   = fb_addr_q;
  assign fb_we     = fb_we_q;
  assign fb_wdata  = wr_phase_q ? bin_data : 8'h00;
  assign y_offset  = y_offset_q;
  assign ready     = ready_q;

endmodule
